// File: rtl/cmd_credit_arbiter_if.sv
// Command request/grant and credit-return bundle for cmd_credit_arbiter.
// master = command engines / response path, slave = the arbiter.
interface cmd_credit_arbiter_if;
    logic       read_req;
    logic       write_req;
    logic       read_grant;
    logic       write_grant;
    logic       resp_valid;
    logic       resp_is_read;
    logic [8:0] resp_credits;

    modport master (
        output read_req,
        output write_req,
        output resp_valid,
        output resp_is_read,
        output resp_credits,
        input  read_grant,
        input  write_grant
    );

    modport slave (
        input  read_req,
        input  write_req,
        input  resp_valid,
        input  resp_is_read,
        input  resp_credits,
        output read_grant,
        output write_grant
    );
endinterface

// File: rtl/cmd_credit_arbiter.sv
// Round-robin read/write command arbiter over split PSL credit pools.
// Optional CMD_CREDIT_STATS_EN adds grant and stall counters.
module cmd_credit_arbiter #(
    parameter int CREDITS_READ  = 32,
    parameter int CREDITS_WRITE = 32,
    parameter int CREDIT_W      = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enabled,
    input  logic [7:0]          room,
    cmd_credit_arbiter_if.slave cmd,
    output logic [CREDIT_W-1:0] credits_read,
    output logic [CREDIT_W-1:0] credits_write,
    output logic [CREDIT_W-1:0] outstanding,
    output logic                drain_done,
    output logic                credit_error
`ifdef CMD_CREDIT_STATS_EN
    ,
    output logic [31:0]         read_grant_count,
    output logic [31:0]         write_grant_count,
    output logic [31:0]         stall_cycles
`endif
);

    localparam int AW = (CREDIT_W > 8 ? CREDIT_W : 8) + 1;
    localparam logic [AW-1:0] RD_MAX = AW'(CREDITS_READ);
    localparam logic [AW-1:0] WR_MAX = AW'(CREDITS_WRITE);
    localparam logic [AW-1:0] TOTAL  = AW'(CREDITS_READ + CREDITS_WRITE);

    typedef enum logic [1:0] {
        IDLE,
        INIT,
        RUN,
        DRAIN
    } state_t;

    state_t              state_q, state_d;
    logic [AW-1:0]       room_q, room_d;
    logic [CREDIT_W-1:0] credits_read_q, credits_read_d;
    logic [CREDIT_W-1:0] credits_write_q, credits_write_d;
    logic [CREDIT_W-1:0] outstanding_q, outstanding_d;
    logic                read_grant_q, read_grant_d;
    logic                write_grant_q, write_grant_d;
    logic                last_rd_q, last_rd_d;
    logic                drain_done_q, drain_done_d;
    logic                credit_error_q, credit_error_d;

    logic          room_gt;
    logic          rd_elig, wr_elig;
    logic          rd_win, wr_win;
    logic          resp_neg, resp_ok;
    logic [AW-1:0] resp_mag;
    logic [AW-1:0] ret_rd, ret_wr;
    logic [AW-1:0] cr_ext, cw_ext;
    logic          ovf_rd, ovf_wr;
    logic [AW-1:0] acc_rd, acc_wr, acc_all;
    logic [AW-1:0] out_sum;

    // FSM: room sampling, drain completion and re-enable
    always_comb begin
        state_d      = state_q;
        room_d       = room_q;
        drain_done_d = 1'b0;
        room_gt      = AW'(room) > TOTAL;
        unique case (state_q)
            IDLE: begin
                if (enabled) state_d = INIT;
            end
            INIT: begin
                room_d  = room_gt ? TOTAL : AW'(room);
                state_d = RUN;
            end
            RUN: begin
                if (!enabled) state_d = DRAIN;
            end
            DRAIN: begin
                if (enabled) begin
                    state_d = RUN;
                end else if (outstanding_q == '0) begin
                    state_d      = IDLE;
                    drain_done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Eligibility and round-robin pick; grant_q blocks a repeat grant
    always_comb begin
        rd_elig = (state_q == RUN) && enabled && cmd.read_req
                  && (credits_read_q != '0)
                  && (AW'(outstanding_q) < room_q)
                  && !read_grant_q;
        wr_elig = (state_q == RUN) && enabled && cmd.write_req
                  && (credits_write_q != '0)
                  && (AW'(outstanding_q) < room_q)
                  && !write_grant_q;
        rd_win        = rd_elig && (!wr_elig || !last_rd_q);
        wr_win        = wr_elig && (!rd_elig || last_rd_q);
        read_grant_d  = rd_win;
        write_grant_d = wr_win;
        last_rd_d     = last_rd_q;
        if (rd_win) last_rd_d = 1'b1;
        if (wr_win) last_rd_d = 1'b0;
    end

    // Net credit update: grant taken and response returned in one step
    always_comb begin
        resp_neg = cmd.resp_credits[8];
        resp_mag = AW'(cmd.resp_credits[7:0]);
        resp_ok  = cmd.resp_valid && (state_q != IDLE)
                   && !resp_neg && (resp_mag != '0);
        ret_rd   = (resp_ok && cmd.resp_is_read) ? resp_mag : '0;
        ret_wr   = (resp_ok && !cmd.resp_is_read) ? resp_mag : '0;
        cr_ext   = AW'(credits_read_q);
        cw_ext   = AW'(credits_write_q);
        ovf_rd   = (cr_ext + ret_rd) > RD_MAX;
        ovf_wr   = (cw_ext + ret_wr) > WR_MAX;
        acc_rd   = ovf_rd ? (RD_MAX - cr_ext) : ret_rd;
        acc_wr   = ovf_wr ? (WR_MAX - cw_ext) : ret_wr;
        acc_all  = acc_rd + acc_wr;
        credits_read_d  = CREDIT_W'(cr_ext - AW'(rd_win) + acc_rd);
        credits_write_d = CREDIT_W'(cw_ext - AW'(wr_win) + acc_wr);
        out_sum = AW'(outstanding_q) + AW'(rd_win) + AW'(wr_win);
        outstanding_d = (out_sum > acc_all)
                        ? CREDIT_W'(out_sum - acc_all) : '0;
        credit_error_d = credit_error_q | ovf_rd | ovf_wr
                         | (cmd.resp_valid
                            && ((state_q == IDLE) || resp_neg));
    end

    // State and counter registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= IDLE;
            room_q          <= '0;
            credits_read_q  <= CREDIT_W'(CREDITS_READ);
            credits_write_q <= CREDIT_W'(CREDITS_WRITE);
            outstanding_q   <= '0;
            read_grant_q    <= 1'b0;
            write_grant_q   <= 1'b0;
            last_rd_q       <= 1'b0;
            drain_done_q    <= 1'b0;
            credit_error_q  <= 1'b0;
        end else begin
            state_q         <= state_d;
            room_q          <= room_d;
            credits_read_q  <= credits_read_d;
            credits_write_q <= credits_write_d;
            outstanding_q   <= outstanding_d;
            read_grant_q    <= read_grant_d;
            write_grant_q   <= write_grant_d;
            last_rd_q       <= last_rd_d;
            drain_done_q    <= drain_done_d;
            credit_error_q  <= credit_error_d;
        end
    end

    assign cmd.read_grant  = read_grant_q;
    assign cmd.write_grant = write_grant_q;
    assign credits_read    = credits_read_q;
    assign credits_write   = credits_write_q;
    assign outstanding     = outstanding_q;
    assign drain_done      = drain_done_q;
    assign credit_error    = credit_error_q;

`ifdef CMD_CREDIT_STATS_EN
    logic [31:0] read_grant_count_q, read_grant_count_d;
    logic [31:0] write_grant_count_q, write_grant_count_d;
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic        stall;

    // Free-running wrap-around statistics
    always_comb begin
        stall = (state_q == RUN) && (cmd.read_req || cmd.write_req)
                && !rd_win && !wr_win;
        read_grant_count_d  = read_grant_count_q + 32'(rd_win);
        write_grant_count_d = write_grant_count_q + 32'(wr_win);
        stall_cycles_d      = stall_cycles_q + 32'(stall);
    end

    // Statistics registers
    always_ff @(posedge clock) begin
        if (reset) begin
            read_grant_count_q  <= '0;
            write_grant_count_q <= '0;
            stall_cycles_q      <= '0;
        end else begin
            read_grant_count_q  <= read_grant_count_d;
            write_grant_count_q <= write_grant_count_d;
            stall_cycles_q      <= stall_cycles_d;
        end
    end

    assign read_grant_count  = read_grant_count_q;
    assign write_grant_count = write_grant_count_q;
    assign stall_cycles      = stall_cycles_q;
`endif

endmodule

// File: tb/tb_cmd_credit_arbiter.sv
// Scoreboard bench for cmd_credit_arbiter: directed phases push
// expected grants/snapshots, one monitor pops and compares.
module tb_cmd_credit_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       enabled;
    logic [7:0] room;
    logic [7:0] credits_read, credits_write, outstanding;
    logic       drain_done, credit_error;
`ifdef CMD_CREDIT_STATS_EN
    logic [31:0] rgc, wgc, stc;
`endif

    cmd_credit_arbiter_if bus ();

    cmd_credit_arbiter dut (
        .clock         (clk),
        .reset         (reset),
        .enabled       (enabled),
        .room          (room),
        .cmd           (bus),
        .credits_read  (credits_read),
        .credits_write (credits_write),
        .outstanding   (outstanding),
        .drain_done    (drain_done),
        .credit_error  (credit_error)
`ifdef CMD_CREDIT_STATS_EN
        ,
        .read_grant_count  (rgc),
        .write_grant_count (wgc),
        .stall_cycles      (stc)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       is_rd;
        logic [7:0] cr;
        logic [7:0] cw;
        logic [7:0] out;
    } gexp_t;

    typedef struct {
        string      nm;
        int         kind;
        logic [7:0] cr;
        logic [7:0] cw;
        logic [7:0] out;
        logic       err;
        logic       dd;
    } chk_t;

    gexp_t sb[$];
    chk_t  cq[$];
    int    checks = 0;
    int    failures = 0;

    function automatic void push_g(input logic r, input int cr,
                                   input int cw, input int out);
        gexp_t e;
        e.is_rd = r;
        e.cr = 8'(cr);
        e.cw = 8'(cw);
        e.out = 8'(out);
        sb.push_back(e);
    endfunction

    function automatic void push_c(input string nm, input int cr,
                                   input int cw, input int out,
                                   input logic err, input logic dd);
        chk_t c;
        c.nm = nm;
        c.kind = 0;
        c.cr = 8'(cr);
        c.cw = 8'(cw);
        c.out = 8'(out);
        c.err = err;
        c.dd = dd;
        cq.push_back(c);
    endfunction

    function automatic void push_k(input string nm, input int kind);
        chk_t c;
        c.nm = nm;
        c.kind = kind;
        c.cr = '0;
        c.cw = '0;
        c.out = '0;
        c.err = 1'b0;
        c.dd = 1'b0;
        cq.push_back(c);
    endfunction

    // Monitor: samples 2ns after each rising edge
    initial begin
        gexp_t e;
        chk_t  c;
        logic  prev_r = 1'b0;
        logic  prev_w = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (bus.read_grant || bus.write_grant) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_grant r=%0d w=%0d required none",
                             bus.read_grant, bus.write_grant);
                end else begin
                    e = sb.pop_front();
                    if (bus.read_grant !== e.is_rd
                        || bus.write_grant !== !e.is_rd
                        || credits_read !== e.cr
                        || credits_write !== e.cw
                        || outstanding !== e.out) begin
                        failures++;
                        $display("FAIL grant got r=%0d w=%0d cr=%0d cw=%0d out=%0d required rd=%0d cr=%0d cw=%0d out=%0d",
                                 bus.read_grant, bus.write_grant,
                                 credits_read, credits_write, outstanding,
                                 e.is_rd, e.cr, e.cw, e.out);
                    end
                end
                checks++;
                if ((bus.read_grant && prev_r)
                    || (bus.write_grant && prev_w)) begin
                    failures++;
                    $display("FAIL back_to_back r=%0d w=%0d prev_r=%0d prev_w=%0d required no repeat",
                             bus.read_grant, bus.write_grant, prev_r, prev_w);
                end
            end
            prev_r = bus.read_grant;
            prev_w = bus.write_grant;
            while (cq.size() != 0) begin
                c = cq.pop_front();
                checks++;
                if (c.kind == 1) begin
                    failures++;
                    $display("FAIL %s timeout waiting for DUT", c.nm);
                end else if (c.kind == 2) begin
                    if (sb.size() != 0) begin
                        failures++;
                        $display("FAIL %s pending_grants=%0d required 0",
                                 c.nm, sb.size());
                    end
                end else if (credits_read !== c.cr
                             || credits_write !== c.cw
                             || outstanding !== c.out
                             || credit_error !== c.err
                             || drain_done !== c.dd) begin
                    failures++;
                    $display("FAIL %s got cr=%0d cw=%0d out=%0d err=%0d dd=%0d required cr=%0d cw=%0d out=%0d err=%0d dd=%0d",
                             c.nm, credits_read, credits_write, outstanding,
                             credit_error, drain_done,
                             c.cr, c.cw, c.out, c.err, c.dd);
                end
            end
        end
    end

    task automatic wait_sb(input string nm, input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) push_k(nm, 1);
    endtask

    task automatic wait_grant(input string nm, input logic rd,
                              input int val, input int budget);
        int  n = 0;
        logic hit = 1'b0;
        while (!hit && n < budget) begin
            @(negedge clk);
            n++;
            if (rd) hit = bus.read_grant && (credits_read == 8'(val));
            else    hit = bus.write_grant && (credits_write == 8'(val));
        end
        if (!hit) push_k(nm, 1);
    endtask

    task automatic resp(input logic v, input logic rd,
                        input logic [8:0] c);
        bus.resp_valid   = v;
        bus.resp_is_read = rd;
        bus.resp_credits = c;
    endtask

    initial begin
        reset         = 1'b1;
        enabled       = 1'b0;
        room          = 8'd64;
        bus.read_req  = 1'b0;
        bus.write_req = 1'b0;
        resp(1'b0, 1'b0, 9'd0);

        // reset state
        @(negedge clk);
        push_c("reset", 32, 32, 0, 1'b0, 1'b0);
        @(negedge clk);

        // read only: 32 grants every other cycle
        reset = 1'b0;
        enabled = 1'b1;
        bus.read_req = 1'b1;
        for (int k = 1; k <= 32; k++) push_g(1'b1, 32 - k, 32, k);
        wait_sb("p1_grants", 120);
        repeat (6) @(negedge clk);
        push_c("p1_end", 0, 32, 32, 1'b0, 1'b0);
        @(negedge clk);

        // both requests: alternate R,W from read
        bus.read_req = 1'b0;
        reset = 1'b1;
        push_c("rst2", 32, 32, 0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        bus.read_req = 1'b1;
        bus.write_req = 1'b1;
        for (int k = 1; k <= 64; k++)
            push_g(k[0], 32 - (k + 1) / 2, 32 - k / 2, k);
        wait_sb("p2_grants", 200);
        repeat (6) @(negedge clk);
        push_c("p2_end", 0, 0, 64, 1'b0, 1'b0);
        @(negedge clk);

        // room = 4 cap, then return of 2 read credits
        bus.read_req = 1'b0;
        bus.write_req = 1'b0;
        room = 8'd4;
        reset = 1'b1;
        push_c("rst3", 32, 32, 0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        bus.read_req = 1'b1;
        bus.write_req = 1'b1;
        push_g(1'b1, 31, 32, 1);
        push_g(1'b0, 31, 31, 2);
        push_g(1'b1, 30, 31, 3);
        push_g(1'b0, 30, 30, 4);
        wait_sb("p3_grants", 40);
        repeat (5) @(negedge clk);
        push_c("p3_capped", 30, 30, 4, 1'b0, 1'b0);
        @(negedge clk);
        resp(1'b1, 1'b1, 9'd2);
        push_c("p3_return", 32, 30, 2, 1'b0, 1'b0);
        push_g(1'b1, 31, 30, 3);
        push_g(1'b0, 31, 29, 4);
        @(negedge clk);
        resp(1'b0, 1'b0, 9'd0);
        wait_sb("p3_more", 20);
        repeat (4) @(negedge clk);
        push_c("p3_end", 31, 29, 4, 1'b0, 1'b0);
        @(negedge clk);

        // grant and return of 3 in the same cycle at credits_read = 10
        bus.read_req = 1'b0;
        bus.write_req = 1'b0;
        room = 8'd64;
        reset = 1'b1;
        push_c("rst4", 32, 32, 0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        bus.read_req = 1'b1;
        for (int k = 1; k <= 22; k++) push_g(1'b1, 32 - k, 32, k);
        wait_grant("p4_reach10", 1'b1, 10, 100);
        @(negedge clk);
        resp(1'b1, 1'b1, 9'd3);
        push_g(1'b1, 12, 32, 20);
        push_c("p4_same_cycle", 12, 32, 20, 1'b0, 1'b0);
        @(negedge clk);
        resp(1'b0, 1'b0, 9'd0);
        bus.read_req = 1'b0;
        @(negedge clk);

        // two write grants, then overflow and negative returns
        bus.write_req = 1'b1;
        push_g(1'b0, 12, 31, 21);
        push_g(1'b0, 12, 30, 22);
        wait_grant("p5_reach30", 1'b0, 30, 20);
        bus.write_req = 1'b0;
        resp(1'b1, 1'b0, 9'd5);
        push_c("p5_overflow", 12, 32, 20, 1'b1, 1'b0);
        @(negedge clk);
        resp(1'b1, 1'b0, 9'h1FF);
        push_c("p5_negative", 12, 32, 20, 1'b1, 1'b0);
        @(negedge clk);

        // bring outstanding to 6, then drain
        resp(1'b1, 1'b1, 9'd14);
        push_c("p6_to_six", 26, 32, 6, 1'b1, 1'b0);
        @(negedge clk);
        resp(1'b0, 1'b0, 9'd0);
        enabled = 1'b0;
        bus.read_req = 1'b1;
        bus.write_req = 1'b1;
        push_c("p6_drain_enter", 26, 32, 6, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        resp(1'b1, 1'b1, 9'd6);
        push_c("p6_returned", 32, 32, 0, 1'b1, 1'b0);
        @(negedge clk);
        resp(1'b0, 1'b0, 9'd0);
        push_c("p6_drain_done", 32, 32, 0, 1'b1, 1'b1);
        @(negedge clk);
        push_c("p6_done_pulse", 32, 32, 0, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        bus.read_req = 1'b0;
        bus.write_req = 1'b0;
        @(negedge clk);

        // re-enable, two grants, drain, then reset mid-drain
        enabled = 1'b1;
        bus.read_req = 1'b1;
        push_g(1'b1, 31, 32, 1);
        push_g(1'b1, 30, 32, 2);
        wait_grant("p7_reach30", 1'b1, 30, 20);
        bus.read_req = 1'b0;
        enabled = 1'b0;
        @(negedge clk);
        push_c("p7_in_drain", 30, 32, 2, 1'b1, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        resp(1'b1, 1'b1, 9'd2);
        push_c("p7_reset_mid_drain", 32, 32, 0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        resp(1'b0, 1'b0, 9'd0);
        push_c("p7_after_reset", 32, 32, 0, 1'b0, 1'b0);
        @(negedge clk);

        // response while IDLE
        resp(1'b1, 1'b1, 9'd3);
        push_c("p8_idle_resp", 32, 32, 0, 1'b1, 1'b0);
        @(negedge clk);
        resp(1'b0, 1'b0, 9'd0);
        reset = 1'b1;
        push_c("rst9", 32, 32, 0, 1'b0, 1'b0);
        @(negedge clk);

        // zero return ignored, negative return flagged in RUN
        reset = 1'b0;
        enabled = 1'b1;
        repeat (2) @(negedge clk);
        resp(1'b1, 1'b1, 9'd0);
        push_c("p9_zero_ret", 32, 32, 0, 1'b0, 1'b0);
        @(negedge clk);
        resp(1'b1, 1'b1, 9'h1FF);
        push_c("p9_neg_ret", 32, 32, 0, 1'b1, 1'b0);
        @(negedge clk);
        resp(1'b0, 1'b0, 9'd0);
        enabled = 1'b0;
        push_k("sb_empty", 2);
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cmd_credit_arbiter.md
Name: cmd_credit_arbiter

Overview:
- Shares the PSL command credit budget between one read-command requester and one write-command requester.
- Keeps separate read and write pools (32 each by default) and a total-outstanding cap from the sampled PSL command room.
- Arbitrates round-robin and grants at most one command per cycle.
- Returns credits when responses arrive; drains cleanly on disable.
- Sits between the read/write command engines and the PSL command interface.

Parameters:
CREDITS_READ, 32, read pool size (max outstanding reads)
CREDITS_WRITE, 32, write pool size (max outstanding writes)
CREDIT_W, 8, width of pool counters; CREDITS_READ+CREDITS_WRITE <= 64

Ports:
clock  in  1  clock
reset  in  1  synchronous active-high reset
enabled  in  1  level; 1 = run, falling edge = drain
room  in  8  PSL command room, sampled in INIT
read_req  in  1  read command pending (level, held until grant)
write_req  in  1  write command pending (level, held until grant)
read_grant  out  1  one-cycle pulse, registered
write_grant  out  1  one-cycle pulse, registered
resp_valid  in  1  response return strobe
resp_is_read  in  1  1 = credits return to read pool, 0 = write pool
resp_credits  in  9  signed returned-credit count
credits_read  out  CREDIT_W  read credits currently available
credits_write  out  CREDIT_W  write credits currently available
outstanding  out  CREDIT_W  total granted, not yet returned
drain_done  out  1  pulse when DRAIN completes
credit_error  out  1  sticky protocol error flag

Behaviour:
- Reset values:
  - credits_read = CREDITS_READ, credits_write = CREDITS_WRITE.
  - outstanding = 0; grants, drain_done and credit_error all 0.
  - State IDLE; room_q = 0; last-winner = write, so read wins the first tie.
- Reset mid-operation: all counters return to reset values immediately. In-flight responses arriving after reset are not counted.
- FSM:
  - IDLE -> INIT when enabled = 1.
  - INIT: room_q <= min(room, CREDITS_READ+CREDITS_WRITE); -> RUN next cycle.
  - RUN -> DRAIN when enabled = 0.
  - DRAIN: no grants issued. -> IDLE with drain_done pulse when outstanding == 0.
  - DRAIN -> RUN if enabled returns to 1 before completion. room_q is not resampled.
- Eligibility in RUN:
  - read eligible = read_req & credits_read > 0 & outstanding < room_q & read_grant == 0.
  - write eligible is symmetric.
  - The "grant == 0" term prevents a double grant while the requester drops its level request.
- Arbitration:
  - Only one side eligible: that side wins.
  - Both eligible: the side that did not win last wins. last-winner updates only on an actual grant.
- Latency: request seen at edge N -> grant high in cycle N+1. Minimum 2 cycles between grants to the same side.
- Counter update on each edge, with grant and return combined in one net computation:
  - Pool: pool' = pool − grant + ret.
  - Total: outstanding' = outstanding + grant − ret.
  - ret = resp_credits if resp_valid, resp_credits > 0 and the pool is selected; else 0.
- Error conditions (each sets credit_error, sticky until reset):
  - Overflow: pool + ret > pool size. Pool saturates at its size; outstanding decrements only by the accepted amount.
  - resp_credits negative: no counter change.
  - resp_valid in IDLE: no counter change.
- resp_credits == 0: ignored, not an error.
- Widths: all arithmetic uses CREDIT_W+1 bits, then clamps. resp_credits is sign-checked before zero-extension.

Optional Feature:
Macro CMD_CREDIT_STATS_EN.
- Defined:
  - Adds 32-bit outputs read_grant_count, write_grant_count and stall_cycles.
  - stall_cycles counts RUN cycles where any request is high but no grant is issued.
  - Counters clear on reset and wrap at 2^32.
- Undefined: these ports and counters do not exist. Core behaviour is identical.

Test Plan:
- Reset, enabled = 1, room = 64, read_req held high, write_req = 0 -> read_grant pulses every 2nd cycle, 32 times; then stops with credits_read = 0 and outstanding = 32.
- Both requests held high, room = 64 -> grants alternate R, W, R, W…; first grant is read; grant to a given side never on consecutive cycles.
- room = 4, both requests high -> exactly 4 grants; then none until resp_valid with resp_is_read = 1 and resp_credits = 2 -> 2 further grants.
- Same cycle: read grant plus read return of 3 with credits_read = 10 -> credits_read = 12; outstanding decreases by 2.
- Return of +5 to the write pool while credits_write = 30 -> credits_write = 32, credit_error = 1; resp_credits = −1 -> counters unchanged.
- enabled -> 0 with outstanding = 6 -> no grants; after 6 credits are returned, drain_done pulses for 1 cycle and state is IDLE. Reset asserted mid-DRAIN -> counters back to 32/32/0 next cycle.
